// File: rtl/dpram_fifo_ctrl.sv
// dpram_fifo_ctrl: turns the 16x8 dual-port RAM into a synchronous FIFO.
// Port 0 of the RAM is written straight from the input stream (no added
// latency). Port 1 is read into a one-word output register. The RAM read is
// registered, so each read takes one extra cycle (rd_pending) before it lands
// in m_data.
module dpram_fifo_ctrl #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   output logic              s_ready,
   output logic              m_valid,
   output logic [DATA_W-1:0] m_data,
   input  logic              m_ready,
   output logic [ADDR_W:0]   count,
   output logic              ram_wr_en,
   output logic              ram_pe0,
   output logic [DATA_W-1:0] ram_din,
   output logic [ADDR_W-1:0] ram_addr0,
   output logic              ram_pe1,
   output logic [ADDR_W-1:0] ram_addr1,
   input  logic [DATA_W-1:0] ram_dout1
);

   localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

   // Pointers carry one extra wrap bit so full (occ=DEPTH) and empty (occ=0)
   // are distinguishable.
   logic [ADDR_W:0]   wr_ptr_reg;
   logic [ADDR_W:0]   rd_ptr_reg;
   logic              rd_pending_reg;
   logic              m_valid_reg;
   logic [DATA_W-1:0] m_data_reg;
   logic [DATA_W-1:0] din_last_reg;
   logic [ADDR_W-1:0] addr0_last_reg;

   logic [ADDR_W:0]   occ;
   logic              push;
   logic              pop;
   logic              issue;

   assign occ = wr_ptr_reg - rd_ptr_reg;

   // rst_n gating keeps the write port quiet while reset is held, since the
   // reset register values alone would otherwise look like "not full".
   assign s_ready = rst_n & (occ < DEPTH_V);
   assign push    = s_valid & s_ready;
   assign pop     = m_valid_reg & m_ready;
   assign issue   = (occ != '0) & ~rd_pending_reg & (~m_valid_reg | pop);

   // Write port is driven combinationally; address/data hold the last write
   // when idle so the RAM pins do not toggle needlessly.
   assign ram_wr_en = push;
   assign ram_pe0   = push;
   assign ram_din   = push ? s_data : din_last_reg;
   assign ram_addr0 = push ? wr_ptr_reg[ADDR_W-1:0] : addr0_last_reg;

   // A read never targets the slot being written: reads only hit occupied
   // slots and writes only free ones.
   assign ram_pe1   = issue;
   assign ram_addr1 = rd_ptr_reg[ADDR_W-1:0];

   assign m_valid = m_valid_reg;
   assign m_data  = m_data_reg;
   assign count   = occ + {{ADDR_W{1'b0}}, rd_pending_reg}
                        + {{ADDR_W{1'b0}}, m_valid_reg};

   // Write side: advance the write pointer and remember the last write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg     <= '0;
         din_last_reg   <= '0;
         addr0_last_reg <= '0;
      end else if (push) begin
         wr_ptr_reg     <= wr_ptr_reg + 1'b1;
         din_last_reg   <= s_data;
         addr0_last_reg <= wr_ptr_reg[ADDR_W-1:0];
      end
   end

   // Read side: issue a RAM read, then capture its data into the output
   // register one cycle later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_reg     <= '0;
         rd_pending_reg <= 1'b0;
         m_valid_reg    <= 1'b0;
         m_data_reg     <= '0;
      end else begin
         if (issue) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         rd_pending_reg <= issue;
         if (rd_pending_reg) begin
            m_data_reg  <= ram_dout1;
            m_valid_reg <= 1'b1;
         end else if (pop) begin
            m_valid_reg <= 1'b0;
         end
      end
   end

endmodule
